// File: rtl/ibex_pkg_pext.sv
// Shared types for the Pext multiply-accumulate sequencer.
//   pext_mac_op_e   : operation select carried on op_i
//   mac_seq_state_e : sequencer state encoding
//   sat32()         : 33-bit signed to 32-bit saturation, returns {ov, result}
package ibex_pkg_pext;

  typedef enum logic [2:0] {
    MADDR32 = 3'd0,
    MSUBR32 = 3'd1,
    KMMAC   = 3'd2,
    KMMACu  = 3'd3,
    KMMSB   = 3'd4,
    KMMSBu  = 3'd5
  } pext_mac_op_e;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PP_LL = 3'd1,
    PP_LH = 3'd2,
    PP_HL = 3'd3,
    PP_HH = 3'd4,
    ACC   = 3'd5,
    DONE  = 3'd6
  } mac_seq_state_e;

  // Bits 32 and 31 disagree exactly when the 33-bit value does not fit in 32 bits.
  function automatic logic [32:0] sat32(input logic [32:0] sum);
    logic [32:0] res;
    if (sum[32] != sum[31]) begin
      res = sum[32] ? {1'b1, 32'h8000_0000} : {1'b1, 32'h7FFF_FFFF};
    end else begin
      res = {1'b0, sum[31:0]};
    end
    return res;
  endfunction

endpackage

// File: rtl/ibex_pext_mul17.sv
// Combinational 17x17 signed multiplier.
//   op_a_i, op_b_i : 17-bit signed operands
//   prod_o         : 34-bit signed product
// Kept standalone so the SIMD 16-bit multiply path can share it.
module ibex_pext_mul17 (
  input  logic [16:0] op_a_i,
  input  logic [16:0] op_b_i,
  output logic [33:0] prod_o
);

  logic signed [33:0] a_ext;
  logic signed [33:0] b_ext;

  // The product of two sign-extended operands, truncated to 34 bits, is exact.
  assign a_ext  = {{17{op_a_i[16]}}, op_a_i};
  assign b_ext  = {{17{op_b_i[16]}}, op_b_i};
  assign prod_o = a_ext * b_ext;

endmodule

// File: rtl/ibex_pext_mac_seq.sv
// Multi-cycle sequencer for the Pext 32x32 multiply-accumulate ops.
// It runs four partial-product cycles on one 17x17 multiplier, then one
// accumulate/saturate cycle against rd, and holds the result in DONE.
//   clk_i, rst_ni               : clock, async active-low reset
//   valid_i/ready_o             : request handshake (op_i, op_a_i, op_b_i, op_c_i)
//   kill_i                      : abort the in-flight op
//   valid_o/ready_i             : result handshake (result_o, ov_o)
module ibex_pext_mac_seq
  import ibex_pkg_pext::*;
#(
  parameter bit ResetAll = 1'b0
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic [2:0]  op_i,
  input  logic [31:0] op_a_i,
  input  logic [31:0] op_b_i,
  input  logic [31:0] op_c_i,
  input  logic        kill_i,
  output logic        valid_o,
  input  logic        ready_i,
  output logic [31:0] result_o,
  output logic        ov_o
);

  mac_seq_state_e state_q;
  pext_mac_op_e   op_q, op_d;
  logic [31:0]    a_q, a_d, b_q, b_d, c_q, c_d;
  logic [63:0]    acc_q, acc_d;
  logic [31:0]    result_q;
  logic           ov_q;

  logic           accept;
  logic [16:0]    mul_a, mul_b;
  logic [33:0]    prod;
  logic [63:0]    pp_ext, pp_term;

  assign ready_o  = (state_q == IDLE);
  assign valid_o  = (state_q == DONE);
  assign result_o = result_q;
  assign ov_o     = ov_q;
  assign accept   = valid_i && ready_o && !kill_i;

  // Operand halves: low halves zero-extended, high halves sign-extended.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    mul_a = {1'b0, a_q[15:0]};
    mul_b = {1'b0, b_q[15:0]};
    unique case (state_q)
      PP_LH:   mul_b = {b_q[31], b_q[31:16]};
      PP_HL:   mul_a = {a_q[31], a_q[31:16]};
      PP_HH: begin
        mul_a = {a_q[31], a_q[31:16]};
        mul_b = {b_q[31], b_q[31:16]};
      end
      default: ;
    endcase
  end

  ibex_pext_mul17 u_mul17 (
    .op_a_i (mul_a),
    .op_b_i (mul_b),
    .prod_o (prod)
  );

  assign pp_ext = {{30{prod[33]}}, prod};

  always_comb begin
    pp_term = pp_ext;
    unique case (state_q)
      PP_LH, PP_HL: pp_term = pp_ext << 16;
      PP_HH:        pp_term = pp_ext << 32;
      default: ;
    endcase
  end

  // Operand/accumulator next state, shared by both reset flavours below.
  always_comb begin
    op_d  = op_q;
    a_d   = a_q;
    b_d   = b_q;
    c_d   = c_q;
    acc_d = acc_q;
    if (accept) begin
      // Unknown encodings behave as MADDR32.
      op_d  = (op_i > 3'd5) ? MADDR32 : pext_mac_op_e'(op_i);
      a_d   = op_a_i;
      b_d   = op_b_i;
      c_d   = op_c_i;
      acc_d = '0;
    end else if (state_q inside {PP_LL, PP_LH, PP_HL, PP_HH}) begin
      acc_d = acc_q + pp_term;
    end
  end

  // Accumulate/saturate. Adding 2^31 before taking bits [63:32] only carries
  // into the high word when acc[31] is set.
  logic        is_sub;
  logic [31:0] acc_hi;
  logic [32:0] sum33;
  logic [32:0] sat_res;
  logic [31:0] acc_result;
  logic        acc_ov;

  always_comb begin
    is_sub  = (op_q == MSUBR32) || (op_q == KMMSB) || (op_q == KMMSBu);
    acc_hi  = ((op_q == KMMACu) || (op_q == KMMSBu)) ?
              acc_q[63:32] + {31'd0, acc_q[31]} : acc_q[63:32];
    sum33   = is_sub ? {c_q[31], c_q} - {acc_hi[31], acc_hi}
                     : {c_q[31], c_q} + {acc_hi[31], acc_hi};
    sat_res = sat32(sum33);
    if ((op_q == MADDR32) || (op_q == MSUBR32)) begin
      acc_result = is_sub ? c_q - acc_q[31:0] : c_q + acc_q[31:0];
      acc_ov     = 1'b0;
    end else begin
      acc_result = sat_res[31:0];
      acc_ov     = sat_res[32];
    end
  end

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every register samples the pre-edge values of its neighbours.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      result_q <= '0;
      ov_q     <= 1'b0;
    end else if (kill_i && (state_q != IDLE)) begin
      state_q <= IDLE;
    end else begin
      unique case (state_q)
        IDLE:  if (accept) state_q <= PP_LL;
        PP_LL: state_q <= PP_LH;
        PP_LH: state_q <= PP_HL;
        PP_HL: state_q <= PP_HH;
        PP_HH: state_q <= ACC;
        ACC: begin
          state_q  <= DONE;
          result_q <= acc_result;
          ov_q     <= acc_ov;
        end
        DONE:    if (ready_i) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // NOTE: datapath registers are only reset when ResetAll is set; every use is
  // gated by the control state, which always loads them before they are read.
  if (ResetAll) begin : g_data_rst
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        op_q  <= MADDR32;
        a_q   <= '0;
        b_q   <= '0;
        c_q   <= '0;
        acc_q <= '0;
      end else begin
        op_q  <= op_d;
        a_q   <= a_d;
        b_q   <= b_d;
        c_q   <= c_d;
        acc_q <= acc_d;
      end
    end
  end else begin : g_data_norst
    always_ff @(posedge clk_i) begin
      op_q  <= op_d;
      a_q   <= a_d;
      b_q   <= b_d;
      c_q   <= c_d;
      acc_q <= acc_d;
    end
  end

  a_legal_op : assert property (@(posedge clk_i) disable iff (!rst_ni)
    (valid_i && ready_o) |-> (op_i <= 3'd5));

  a_result_stable : assert property (@(posedge clk_i) disable iff (!rst_ni)
    (valid_o && !ready_i) |=> $stable(result_o));

  a_valid_ready_excl : assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(valid_o && ready_o));

endmodule

// File: tb/tb_ibex_pext_mac_seq.sv
// Directed self-checking bench for ibex_pext_mac_seq.
module tb_ibex_pext_mac_seq;
  import ibex_pkg_pext::*;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic [2:0]  op_i = 3'd0;
  logic [31:0] op_a_i = '0;
  logic [31:0] op_b_i = '0;
  logic [31:0] op_c_i = '0;
  logic        kill_i = 1'b0;
  logic        valid_o;
  logic        ready_i = 1'b0;
  logic [31:0] result_o;
  logic        ov_o;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk_i = ~clk_i;

  ibex_pext_mac_seq #(.ResetAll(1'b0)) dut (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .valid_i  (valid_i),
    .ready_o  (ready_o),
    .op_i     (op_i),
    .op_a_i   (op_a_i),
    .op_b_i   (op_b_i),
    .op_c_i   (op_c_i),
    .kill_i   (kill_i),
    .valid_o  (valid_o),
    .ready_i  (ready_i),
    .result_o (result_o),
    .ov_o     (ov_o)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_assert++;
    assert (observed === expected) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Issue one op, expect valid_o exactly 5 edges after the accepting edge,
  // optionally stall the result for `hold` cycles, then complete the handshake.
  task automatic run_op(input string tag, input pext_mac_op_e op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] c,
                        input logic [31:0] exp_res, input logic exp_ov, input int hold);
    int lat;
    logic [31:0] held;
    check({tag, "_ready_before"}, {31'd0, ready_o}, 32'd1);
    op_i    = op;
    op_a_i  = a;
    op_b_i  = b;
    op_c_i  = c;
    valid_i = 1'b1;
    ready_i = (hold == 0);
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    lat = 0;
    while (!valid_o && lat < 20) begin
      @(posedge clk_i); #1;
      lat++;
    end
    check({tag, "_latency"}, lat, 32'd5);
    check({tag, "_result"}, result_o, exp_res);
    check({tag, "_ov"}, {31'd0, ov_o}, {31'd0, exp_ov});
    held = result_o;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk_i); #1;
      check({tag, "_hold_valid"}, {31'd0, valid_o}, 32'd1);
      check({tag, "_hold_ready"}, {31'd0, ready_o}, 32'd0);
      check({tag, "_hold_result"}, result_o, held);
    end
    ready_i = 1'b1;
    @(posedge clk_i); #1;
    ready_i = 1'b0;
    check({tag, "_ready_after"}, {31'd0, ready_o}, 32'd1);
    check({tag, "_valid_after"}, {31'd0, valid_o}, 32'd0);
  endtask

  initial begin
    // Reset state
    #1;
    check("rst_ready", {31'd0, ready_o}, 32'd1);
    check("rst_valid", {31'd0, valid_o}, 32'd0);
    check("rst_result", result_o, 32'd0);
    check("rst_ov", {31'd0, ov_o}, 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i); #1;

    // Arithmetic
    run_op("maddr32",       MADDR32, 32'd3,         32'd5,         32'd10,        32'h0000_0019, 1'b0, 0);
    run_op("msubr32",       MSUBR32, 32'hFFFF_FFFF, 32'd2,         32'd0,         32'h0000_0002, 1'b0, 0);
    run_op("maddr32_hh",    MADDR32, 32'h0001_0000, 32'h0001_0000, 32'd1,         32'h0000_0001, 1'b0, 0);
    run_op("maddr32_neg",   MADDR32, 32'hFFFF_0000, 32'd3,         32'd0,         32'hFFFD_0000, 1'b0, 0);
    run_op("kmmac_sat",     KMMAC,   32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1, 0);
    run_op("kmmsb_sat",     KMMSB,   32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000, 32'h8000_0000, 1'b1, 0);
    run_op("kmmac_trunc",   KMMAC,   32'd1,         32'h8000_0000, 32'd0,         32'hFFFF_FFFF, 1'b0, 0);
    run_op("kmmacu_rnd",    KMMACu,  32'd1,         32'h8000_0000, 32'd0,         32'h0000_0000, 1'b0, 0);
    run_op("kmmacu_min",    KMMACu,  32'h8000_0000, 32'h8000_0000, 32'd0,         32'h4000_0000, 1'b0, 0);
    run_op("kmmsb_trunc",   KMMSB,   32'd1,         32'h8000_0000, 32'd0,         32'h0000_0001, 1'b0, 0);
    run_op("kmmsbu_rnd",    KMMSBu,  32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'd0,         32'hC000_0001, 1'b0, 0);

    // Backpressure: hold the result for 3 cycles in DONE
    run_op("bp", KMMAC, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1, 3);

    // Kill in PP_HL: accepting edge, then PP_LL, PP_LH, PP_HL
    op_i = MADDR32; op_a_i = 32'd7; op_b_i = 32'd7; op_c_i = 32'd0;
    valid_i = 1'b1; ready_i = 1'b1;
    @(posedge clk_i); #1;          // now in PP_LL
    valid_i = 1'b0;
    @(posedge clk_i); #1;          // PP_LH
    @(posedge clk_i); #1;          // PP_HL
    kill_i = 1'b1;
    @(posedge clk_i); #1;
    kill_i = 1'b0;
    check("kill_ready", {31'd0, ready_o}, 32'd1);
    check("kill_valid", {31'd0, valid_o}, 32'd0);
    begin
      int seen = 0;
      for (int i = 0; i < 8; i++) begin
        @(posedge clk_i); #1;
        if (valid_o) seen++;
      end
      check("kill_no_valid", seen, 32'd0);
    end

    // Kill with valid_i in IDLE blocks the accept
    valid_i = 1'b1; kill_i = 1'b1;
    @(posedge clk_i); #1;
    valid_i = 1'b0; kill_i = 1'b0;
    check("kill_idle_ready", {31'd0, ready_o}, 32'd1);

    // Mid-operation asynchronous reset; result_o is nonzero from the bp op
    check("pre_rst_result", result_o, 32'h7FFF_FFFF);
    op_i = KMMAC; op_a_i = 32'd5; op_b_i = 32'd5; op_c_i = 32'd1;
    valid_i = 1'b1;
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    @(posedge clk_i); #2;
    rst_ni = 1'b0;
    #1;
    check("midrst_ready", {31'd0, ready_o}, 32'd1);
    check("midrst_valid", {31'd0, valid_o}, 32'd0);
    check("midrst_result", result_o, 32'd0);
    check("midrst_ov", {31'd0, ov_o}, 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i); #1;

    // Normal operation after reset
    run_op("post_rst", MADDR32, 32'd3, 32'd5, 32'd10, 32'h0000_0019, 1'b0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
